sdm_dec: RTL and testbench

- Sigma-delta decimator: the receiving end of a 1-bit sigma-delta serial link.
- Samples the 1-bit `rx` stream on each rising edge of the slow bit clock `fclk`.
- Accumulate-and-dump (sinc1) over 2^OSR_LOG2 bits, scales the result to a signed DMSB+1-bit sample and holds it in a one-entry buffer.
- Buffer uses the full/pop toggle handshake used by the link's host side.
- All logic runs in the `clk` domain; `fclk` and `rx` are asynchronous inputs.

---
 rtl/sdm_dec.sv | 81 ++++++++
 tb/tb_sdm_dec.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sdm_dec.sv
// sdm_dec: sinc1 decimator for a 1-bit sigma-delta link with a toggle-handshake sample buffer
module sdm_dec #(
  parameter int DMSB     = 3,
  parameter int OSR_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               setn,
  input  logic               fclk,
  input  logic               rx,
  input  logic               pop,
  input  logic               clear,
  output logic               full,
  output logic               ovf,
  output logic signed [DMSB:0] rdata,
  output logic               tick,
  output logic [1:0]         cst
);
  localparam int A  = OSR_LOG2 + 2;
  localparam int SH = OSR_LOG2 - DMSB;
  localparam logic signed [A-1:0] SMAX = A'((1 << DMSB) - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, RUN = 2'd2} st_t;
  st_t st_q, st_d;
  logic [1:0] fs_q, rs_q;
  logic fe_q, rb_q, tick_q, pop_q, full_q, full_d, ovf_q, ovf_d;
  logic signed [A-1:0] acc_q, acc_d, step, sum, shf;
  logic [OSR_LOG2-1:0] cnt_q, cnt_d;
  logic signed [DMSB:0] rd_q, rd_d, sample;
  logic run, win, pop_ev, load, flush;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fs_q   <= '0;
      fe_q   <= 1'b0;
      rs_q   <= '0;
      rb_q   <= 1'b0;
      tick_q <= 1'b0;
      pop_q  <= 1'b0;
      st_q   <= IDLE;
      acc_q  <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      rd_q   <= '0;
    end else begin
      fs_q   <= {fs_q[0], fclk};
      fe_q   <= fs_q[1];
      tick_q <= fs_q[1] & ~fe_q;
      rs_q   <= {rs_q[0], rx};
      rb_q   <= rs_q[1];
      pop_q  <= pop;
      st_q   <= st_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
      rd_q   <= rd_d;
    end
  end
  always_comb begin
    step   = rb_q ? A'(1) : '1;
    sum    = acc_q + step;
    shf    = sum >>> SH;
    sample = (shf > SMAX) ? SMAX[DMSB:0] : shf[DMSB:0];
    run    = (st_q == RUN) && setn && tick_q;
    win    = run && (&cnt_q);
    pop_ev = pop ^ pop_q;
    load   = win && (!full_q || pop_ev);
    flush  = clear || !setn || win;
    st_d   = !setn ? IDLE : (st_q == IDLE) ? SYNC : (st_q == SYNC && tick_q) ? RUN : st_q;
    acc_d  = flush ? '0 : run ? sum : acc_q;
    cnt_d  = flush ? '0 : run ? cnt_q + OSR_LOG2'(1) : cnt_q;
    full_d = clear ? 1'b0 : load ? 1'b1 : pop_ev ? 1'b0 : full_q;
    ovf_d  = clear ? 1'b0 : (win && full_q && !pop_ev) ? 1'b1 : ovf_q;
    rd_d   = clear ? '0 : load ? sample : rd_q;
  end
  assign full  = full_q;
  assign ovf   = ovf_q;
  assign rdata = rd_q;
  assign tick  = tick_q;
  assign cst   = st_q;
endmodule

// File: tb/tb_sdm_dec.sv
// tb_sdm_dec: directed table-driven checks of the sigma-delta decimator
module tb_sdm_dec;
  logic clk = 1'b0, rstn = 1'b0, setn = 1'b0, fclk = 1'b0, rx = 1'b0, pop = 1'b0, clear = 1'b0;
  logic full, ovf, tick;
  logic [3:0] rdata;
  logic [1:0] cst;
  int checks = 0, errors = 0, ticks = 0;
  typedef struct packed {logic [15:0] pat; logic [3:0] exp;} vec_t;
  vec_t v[10];

  sdm_dec #(.DMSB(3), .OSR_LOG2(4)) dut (
    .clk(clk), .rstn(rstn), .setn(setn), .fclk(fclk), .rx(rx), .pop(pop), .clear(clear),
    .full(full), .ovf(ovf), .rdata(rdata), .tick(tick), .cst(cst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic pop_on_tick);
    rx = b;
    repeat (2) @(negedge clk);
    fclk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tick) begin
        ticks++;
        if (pop_on_tick) pop = ~pop;
      end
    end
    fclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_win(input logic [15:0] p, input logic pop_last);
    for (int i = 0; i < 16; i++) send_bit(p[i], pop_last && i == 15);
  endtask

  task automatic toggle_pop();
    pop = ~pop;
    @(negedge clk);
  endtask

  initial begin
    v[0] = '{16'hFFFF, 4'h7};
    v[1] = '{16'h0000, 4'h8};
    v[2] = '{16'h5555, 4'h0};
    v[3] = '{16'h0FFF, 4'h4};
    v[4] = '{16'h00FF, 4'h0};
    v[5] = '{16'h0007, 4'hB};
    v[6] = '{16'h007F, 4'hF};
    v[7] = '{16'h7FFF, 4'h7};
    v[8] = '{16'h3FFF, 4'h6};
    v[9] = '{16'h0001, 4'h9};
    repeat (3) @(negedge clk);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_rdata", int'(rdata), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_cst", int'(cst), 0);
    rstn = 1'b1;
    setn = 1'b1;
    @(negedge clk);
    chk("sync_cst", int'(cst), 1);
    ticks = 0;
    send_bit(1'b1, 1'b0);
    chk("align_tick", ticks, 1);
    chk("run_cst", int'(cst), 2);
    chk("align_full", int'(full), 0);
    for (int k = 0; k < 10; k++) begin
      send_win(v[k].pat, 1'b0);
      chk($sformatf("v%0d_rdata", k), int'(rdata), int'(v[k].exp));
      chk($sformatf("v%0d_full", k), int'(full), 1);
      chk($sformatf("v%0d_ovf", k), int'(ovf), 0);
      toggle_pop();
      chk($sformatf("v%0d_popped", k), int'(full), 0);
      chk($sformatf("v%0d_hold", k), int'(rdata), int'(v[k].exp));
    end
    ticks = 0;
    send_win(16'hFFFF, 1'b0);
    chk("win_ticks", ticks, 16);
    send_win(16'h0000, 1'b0);
    chk("ovr_rdata", int'(rdata), 7);
    chk("ovr_full", int'(full), 1);
    chk("ovr_ovf", int'(ovf), 1);
    toggle_pop();
    chk("ovr_pop_full", int'(full), 0);
    chk("ovr_pop_ovf", int'(ovf), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_ovf", int'(ovf), 0);
    chk("clr_rdata", int'(rdata), 0);
    chk("clr_full", int'(full), 0);
    chk("clr_cst", int'(cst), 2);
    send_win(16'h0FFF, 1'b0);
    chk("pre_sim_rdata", int'(rdata), 4);
    send_win(16'h0000, 1'b1);
    chk("sim_rdata", int'(rdata), 8);
    chk("sim_full", int'(full), 1);
    chk("sim_ovf", int'(ovf), 0);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_full", int'(full), 0);
    chk("mid_rst_rdata", int'(rdata), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    chk("mid_rst_cst", int'(cst), 0);
    @(negedge clk);
    pop = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    chk("re_sync_cst", int'(cst), 1);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    chk("re_sync_hold", int'(cst), 1);
    fclk = 1'b1;
    repeat (6) @(negedge clk);
    fclk = 1'b0;
    repeat (2) @(negedge clk);
    chk("re_run_cst", int'(cst), 2);
    send_win(16'hFFFF, 1'b0);
    chk("re_rdata", int'(rdata), 7);
    chk("re_full", int'(full), 1);
    setn = 1'b0;
    @(negedge clk);
    chk("idle_cst", int'(cst), 0);
    chk("idle_full", int'(full), 1);
    chk("idle_rdata", int'(rdata), 7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
